wr_xfer_arbiter: RTL and testbench
==================================

# wr_xfer_arbiter

Round-robin arbiter that shares one AXI4 write-master command/stream port between `NUM_REQ` write engines of the memory-tester kernel. Each engine issues a one-cycle transfer request with address and size; the arbiter latches it, grants whole transfers one at a time, and routes the stream handshake to the owner. It returns the master's completion pulse to the owning engine only. It sits between the `mem_write` engine instances and the AXI write master.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `C_AXIS_TDATA_WIDTH`, 256, stream data width
- `C_M_AXI_ADDR_WIDTH`, 64, address width
- `C_XFER_SIZE_WIDTH`, 32, transfer size width
- `CNT_WIDTH`, 32, completed-transfer counter width

Clock and reset: reset `reset`, synchronous, active-high; clock `clk`.

- `clk` in 1 — clock
- `reset` in 1 — synchronous, active-high reset
- `req_write_out_data` in [NUM_REQ] — one-cycle request pulse per requester
- `req_write_addr` in [NUM_REQ][C_M_AXI_ADDR_WIDTH] — address, sampled with the pulse
- `req_out_data_size` in [NUM_REQ][C_XFER_SIZE_WIDTH] — size, sampled with the pulse
- `req_out_data_valid` in [NUM_REQ] — stream valid
- `req_out_data` in [NUM_REQ][C_AXIS_TDATA_WIDTH] — stream data
- `req_out_data_ready` out [NUM_REQ] — stream ready; owner only
- `req_write_done` out [NUM_REQ] — one-cycle completion pulse to the owner
- `m_write_out_data` out 1 — one-cycle command pulse to the master
- `m_write_addr` out C_M_AXI_ADDR_WIDTH — latched address
- `m_out_data_size` out C_XFER_SIZE_WIDTH — latched size
- `m_out_data_valid` out 1 — routed valid
- `m_out_data` out C_AXIS_TDATA_WIDTH — routed data
- `m_out_data_ready` in 1 — master ready
- `m_write_done` in 1 — master completion pulse
- `grant_id` out $clog2(NUM_REQ) — current or last owner
- `busy` out 1 — high in any state other than IDLE
- `xfer_count` out CNT_WIDTH — completed transfers, wraps
- `protocol_err` out 1 — sticky error flag

## Operation

**Request capture**
- Per requester: `pending[i]`, plus address and size registers.
- A pulse with `pending[i]=0` sets `pending[i]` and captures address and size.
- A pulse with `pending[i]=1` is ignored, except in the clear cycle below. It sets `protocol_err`.

**State machine `arb_state_t`:** IDLE, ISSUE, STREAM, DONE.
- **IDLE:** if any `pending`, pick the first set bit starting at `rr_ptr`, searching upward with wrap. Register `grant_id`, drive `m_write_addr` and `m_out_data_size` from that requester's latched registers, set `m_write_out_data`<=1, go to ISSUE.
- **ISSUE:** `m_write_out_data`<=0.
  - If `m_write_done`, go to DONE.
  - Otherwise go to STREAM.
- **STREAM:** combinational routing.
  - `m_out_data_valid`=`req_out_data_valid[grant_id]` and `m_out_data`=`req_out_data[grant_id]`.
  - `req_out_data_ready[grant_id]`=`m_out_data_ready`; all other ready bits are 0.
  - On `m_write_done`, go to DONE.
- **DONE:** `req_write_done[grant_id]`=1 for this one cycle. Clear `pending[grant_id]`, set `rr_ptr`<=`grant_id+1` (mod NUM_REQ), increment `xfer_count`, go to IDLE.
  - If the owner pulses in this same cycle, the new request wins: `pending` stays set and the new command is captured. No error is flagged.

**Routing outside STREAM**
- `m_out_data_valid`=0, `m_out_data`=0, all `req_out_data_ready`=0.

**Done pulses outside ISSUE/STREAM**
- `m_write_done` in IDLE or DONE is dropped and sets `protocol_err`.

**Reset values**
- All outputs 0.
- `state`=IDLE, `pending`=0, `rr_ptr`=0.
- Reset mid-transfer abandons the transfer with no done pulse.

## Timing
- Request pulse in cycle N, arbiter idle: `m_write_out_data` is high in cycle N+2 and STREAM begins in N+3.
- Data path in STREAM is zero-latency combinational, in both directions.
- `m_write_done` in cycle M (in STREAM) gives `req_write_done` high in M+1 (DONE) and IDLE in M+2. The next grant's command pulse is at M+3 at the earliest.
- `m_write_addr`, `m_out_data_size` and `grant_id` are held stable from ISSUE until the next grant.
- Fairness: with all requesters continuously pending, grants rotate 0,1,…,NUM_REQ-1,0.

## Structure
- Shared package `mem_test_pkg` holds `arb_state_t` and the `MAX_REQ`=8 constant.
- One sub-module, `rr_pick`: a combinational round-robin first-set finder.
  - Inputs: `pending`, `rr_ptr`.
  - Outputs: `idx`, `found`.

## Test plan
- **Single request:** req0 pulses with addr=0x1000, size=32 → `m_write_out_data` pulses at N+2 with addr=0x1000, size=32. 4 beats route with `req_out_data_ready[1]`=0. `m_write_done` → `req_write_done[0]` the next cycle; `xfer_count`=1.
- **Contention:** req0 and req1 pulse in the same cycle → req0 is served first, then req1. Repeating both → order 0,1,0,1.
- **Backpressure:** `m_out_data_ready` toggles every cycle during STREAM → owner ready mirrors it and data arrives in order. The non-owner's valid and data never reach `m_out_*`.
- **Re-request in DONE:** req0 pulses in its own DONE cycle with addr=0x2000 → req0 is regranted with 0x2000 when no other requester is pending; `protocol_err`=0.
- **Errors:** duplicate pulse while pending sets `protocol_err`=1 and the original address is kept. Stray `m_write_done` in IDLE also sets `protocol_err`=1.
- **Reset mid-STREAM:** → all outputs 0 the next cycle, no `req_write_done`, `pending`=0.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types for the memory-tester kernel.
//   arb_state_t : write-transfer arbiter state encoding
//   MAX_REQ     : largest number of write engines an arbiter may serve
package mem_test_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/wr_xfer_arbiter_rr_pick.sv
// Combinational round-robin first-set finder.
//   pending : request bits, one per requester
//   rr_ptr  : index the search starts at (searching upward, wrapping)
//   idx     : first set index found from rr_ptr
//   found   : any pending bit set
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      idx,
    output logic               found
);

    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && pending[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/wr_xfer_arbiter.sv
// Round-robin arbiter sharing one AXI4 write-master command/stream port
// between NUM_REQ write engines. Whole transfers are granted one at a time.
//   req_write_out_data/addr/size : per-engine one-cycle request + command
//   req_out_data_valid/data/ready: per-engine stream, routed to owner only
//   req_write_done               : completion pulse back to the owner
//   m_*                          : command/stream/completion toward master
//   grant_id, busy, xfer_count, protocol_err : status
module wr_xfer_arbiter
    import mem_test_pkg::*;
#(
    parameter int NUM_REQ            = 2,
    parameter int C_AXIS_TDATA_WIDTH = 256,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int CNT_WIDTH          = 32,
    parameter int IW                 = $clog2(NUM_REQ)
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_REQ-1:0]                               req_write_out_data,
    input  logic [NUM_REQ-1:0][C_M_AXI_ADDR_WIDTH-1:0]       req_write_addr,
    input  logic [NUM_REQ-1:0][C_XFER_SIZE_WIDTH-1:0]        req_out_data_size,
    input  logic [NUM_REQ-1:0]                               req_out_data_valid,
    input  logic [NUM_REQ-1:0][C_AXIS_TDATA_WIDTH-1:0]       req_out_data,
    output logic [NUM_REQ-1:0]                               req_out_data_ready,
    output logic [NUM_REQ-1:0]                               req_write_done,
    output logic                                             m_write_out_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                    m_write_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]                     m_out_data_size,
    output logic                                             m_out_data_valid,
    output logic [C_AXIS_TDATA_WIDTH-1:0]                    m_out_data,
    input  logic                                             m_out_data_ready,
    input  logic                                             m_write_done,
    output logic [IW-1:0]                                    grant_id,
    output logic                                             busy,
    output logic [CNT_WIDTH-1:0]                             xfer_count,
    output logic                                             protocol_err
);

    arb_state_t                                state;
    logic [NUM_REQ-1:0]                        pending;
    logic [NUM_REQ-1:0][C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [NUM_REQ-1:0][C_XFER_SIZE_WIDTH-1:0]  size_q;
    logic [IW-1:0]                             rr_ptr;
    logic [IW-1:0]                             pick_idx;
    logic                                      pick_found;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            pending          <= '0;
            addr_q           <= '0;
            size_q           <= '0;
            rr_ptr           <= '0;
            grant_id         <= '0;
            m_write_out_data <= 1'b0;
            m_write_addr     <= '0;
            m_out_data_size  <= '0;
            req_write_done   <= '0;
            xfer_count       <= '0;
            protocol_err     <= 1'b0;
        end else begin
            m_write_out_data <= 1'b0;
            req_write_done   <= '0;

            // The owner may re-request in its own DONE cycle: that pulse
            // replaces the command being retired instead of flagging an error.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_write_out_data[i]) begin
                    if (!pending[i] || (state == DONE && grant_id == IW'(i))) begin
                        pending[i] <= 1'b1;
                        addr_q[i]  <= req_write_addr[i];
                        size_q[i]  <= req_out_data_size[i];
                    end else begin
                        protocol_err <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (m_write_done) protocol_err <= 1'b1;
                    if (pick_found) begin
                        grant_id         <= pick_idx;
                        m_write_addr     <= addr_q[pick_idx];
                        m_out_data_size  <= size_q[pick_idx];
                        m_write_out_data <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE, STREAM: begin
                    if (m_write_done) begin
                        req_write_done[grant_id] <= 1'b1;
                        state                    <= DONE;
                    end else begin
                        state <= STREAM;
                    end
                end
                DONE: begin
                    if (m_write_done) protocol_err <= 1'b1;
                    if (!req_write_out_data[grant_id]) pending[grant_id] <= 1'b0;
                    rr_ptr     <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    xfer_count <= xfer_count + CNT_WIDTH'(1);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency stream routing; only the owner sees ready.
    always_comb begin
        m_out_data_valid   = 1'b0;
        m_out_data         = '0;
        req_out_data_ready = '0;
        if (state == STREAM) begin
            m_out_data_valid             = req_out_data_valid[grant_id];
            m_out_data                   = req_out_data[grant_id];
            req_out_data_ready[grant_id] = m_out_data_ready;
        end
    end

endmodule

// File: tb/tb_wr_xfer_arbiter.sv
// Randomized self-checking bench for wr_xfer_arbiter. A transaction-level
// model tracks which requests are outstanding (with the cycle they arrived)
// and predicts each grant, command contents, completion pulses, counter,
// error flag and stream routing from the arbitration rules.
module tb_wr_xfer_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int AW = 64;
    localparam int SW = 32;
    localparam int CW = 32;
    localparam int IW = $clog2(N);
    localparam int NCYC = 6000;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N-1:0]             req_write_out_data;
    logic [N-1:0][AW-1:0]     req_write_addr;
    logic [N-1:0][SW-1:0]     req_out_data_size;
    logic [N-1:0]             req_out_data_valid;
    logic [N-1:0][DW-1:0]     req_out_data;
    logic [N-1:0]             req_out_data_ready;
    logic [N-1:0]             req_write_done;
    logic                     m_write_out_data;
    logic [AW-1:0]            m_write_addr;
    logic [SW-1:0]            m_out_data_size;
    logic                     m_out_data_valid;
    logic [DW-1:0]            m_out_data;
    logic                     m_out_data_ready;
    logic                     m_write_done;
    logic [IW-1:0]            grant_id;
    logic                     busy;
    logic [CW-1:0]            xfer_count;
    logic                     protocol_err;

    always #5 clk = ~clk;

    wr_xfer_arbiter #(
        .NUM_REQ(N), .C_AXIS_TDATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW),
        .C_XFER_SIZE_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_write_out_data(req_write_out_data), .req_write_addr(req_write_addr),
        .req_out_data_size(req_out_data_size), .req_out_data_valid(req_out_data_valid),
        .req_out_data(req_out_data), .req_out_data_ready(req_out_data_ready),
        .req_write_done(req_write_done), .m_write_out_data(m_write_out_data),
        .m_write_addr(m_write_addr), .m_out_data_size(m_out_data_size),
        .m_out_data_valid(m_out_data_valid), .m_out_data(m_out_data),
        .m_out_data_ready(m_out_data_ready), .m_write_done(m_write_done),
        .grant_id(grant_id), .busy(busy), .xfer_count(xfer_count),
        .protocol_err(protocol_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Model state: outstanding requests with arrival cycle and latched command.
    bit          mp[N];
    int          mt[N];
    logic [AW-1:0] ma[N];
    logic [SW-1:0] ms[N];
    int          rr, cnt;
    bit          err;
    int          tst;          // 0: no grant, 1: transfer running, 2: done cycle
    int          owner, c_cyc, x_end, idle_since;
    logic [AW-1:0] ex_addr;
    logic [SW-1:0] ex_size;
    int          ex_gid;

    // A request pulsed in cycle t can win a pick made in cycle t+1 or later,
    // and that pick shows up as a command pulse one cycle after the pick.
    function automatic int pick(input int cyc);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (mp[j] && mt[j] <= cyc - 2) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mp[i] = 1'b0; mt[i] = 0; ma[i] = '0; ms[i] = '0;
        end
        rr = 0; cnt = 0; err = 1'b0; tst = 0; owner = 0;
        c_cyc = 0; x_end = 0; ex_addr = '0; ex_size = '0; ex_gid = 0;
    endtask

    task automatic rand_stream();
        for (int i = 0; i < N; i++) begin
            req_out_data_valid[i] = 1'($urandom_range(0, 1));
            for (int w = 0; w < DW / 32; w++) req_out_data[i][w*32 +: 32] = $urandom;
        end
        m_out_data_ready = 1'($urandom_range(0, 1));
    endtask

    int            p, rate;
    bit            rst_now, want_rst, err_n, repulse, stream;
    logic [N-1:0]  exp_done, exp_rdy;

    initial begin
        reset = 1'b1;
        req_write_out_data = '0; req_write_addr = '0; req_out_data_size = '0;
        req_out_data_valid = '0; req_out_data = '0;
        m_out_data_ready = 1'b0; m_write_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd",  m_write_out_data, 0);
        check("rst_addr", m_write_addr, 0);
        check("rst_size", m_out_data_size, 0);
        check("rst_gid",  grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt",  xfer_count, 0);
        check("rst_err",  protocol_err, 0);
        check("rst_done", req_write_done, 0);
        check("rst_mval", m_out_data_valid, 0);
        check("rst_rdy",  req_out_data_ready, 0);
        reset = 1'b0;
        model_reset();
        idle_since = 0;
        want_rst   = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Registered outputs for this cycle.
            p = (tst == 0 && cyc - 1 >= idle_since) ? pick(cyc) : -1;
            exp_done = '0;
            if (tst == 2) exp_done[owner] = 1'b1;
            check("cmd",  m_write_out_data, p >= 0);
            check("done", req_write_done, exp_done);
            check("err",  protocol_err, err);
            check("cnt",  xfer_count, cnt);
            check("busy", busy, (tst != 0) || (p >= 0));
            if (p >= 0) begin
                owner = p; c_cyc = cyc; x_end = cyc + $urandom_range(0, 4);
                ex_addr = ma[p]; ex_size = ms[p]; ex_gid = p; tst = 1;
            end
            check("addr", m_write_addr, ex_addr);
            check("size", m_out_data_size, ex_size);
            check("gid",  grant_id, ex_gid);

            // Drive this cycle's inputs.
            if (cyc % 600 == 300) want_rst = 1'b1;
            rst_now = want_rst && tst == 1 && cyc > c_cyc;
            err_n   = 1'b0;
            repulse = 1'b0;
            rand_stream();
            if (rst_now) begin
                want_rst = 1'b0;
                reset = 1'b1;
                req_write_out_data = '0;
                m_write_done = 1'b0;
            end else begin
                reset = 1'b0;
                rate = (cyc < 2000) ? 10 : (cyc < 4000) ? 4 : 2;
                for (int i = 0; i < N; i++) begin
                    req_write_out_data[i] = ($urandom_range(0, rate - 1) == 0);
                    req_write_addr[i]     = {$urandom, $urandom};
                    req_out_data_size[i]  = $urandom;
                    if (req_write_out_data[i]) begin
                        if (mp[i] && !(tst == 2 && i == owner)) begin
                            err_n = 1'b1;
                        end else begin
                            if (tst == 2 && i == owner) repulse = 1'b1;
                            mp[i] = 1'b1; mt[i] = cyc;
                            ma[i] = req_write_addr[i]; ms[i] = req_out_data_size[i];
                        end
                    end
                end
                if (tst == 1) begin
                    m_write_done = (cyc == x_end);
                end else begin
                    m_write_done = ($urandom_range(0, 199) == 0);
                    if (m_write_done) err_n = 1'b1;
                end
            end

            // Combinational routing.
            #1;
            stream  = (tst == 1) && (cyc > c_cyc);
            exp_rdy = '0;
            if (stream) exp_rdy[owner] = m_out_data_ready;
            check("mval", m_out_data_valid, stream ? req_out_data_valid[owner] : 1'b0);
            check("mdat", m_out_data, stream ? req_out_data[owner] : '0);
            check("rdy",  req_out_data_ready, exp_rdy);

            // Advance the model.
            if (rst_now) begin
                model_reset();
                idle_since = cyc + 1;
            end else begin
                if (tst == 2) begin
                    if (!repulse) mp[owner] = 1'b0;
                    rr = (owner + 1) % N;
                    cnt++;
                    tst = 0;
                    idle_since = cyc + 1;
                end else if (tst == 1 && m_write_done) begin
                    tst = 2;
                end
                if (err_n) err = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
